smpc_port_poller: RTL and testbench



---
 rtl/smpc_port_poller.sv | 220 ++++++++++++++++++++++
 tb/tb_smpc_port_poller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smpc_port_poller.sv
// rtl/smpc_port_poller.sv - autonomous TH/TR/TL nibble-handshake port scanner with paged output buffer
//
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   CE               clock enable; FSM, timers and buffer writes advance only on CE
//   START/CONT/BRK   command strobes: begin scan, continue after full page, abort scan
//   PEN[NPORTS]      per-port enable
//   PO[7*NPORTS]     port pins out, per port bit6=TH, bit5=TR, other bits 1
//   PI[7*NPORTS]     port pins in, per port bit4=TL, bits3:0=data nibble
//   RADDR/RDATA      host buffer read, RDATA registered with 1 CLK latency
//   BUSY             scan in progress (including waiting on a full page)
//   PAGE_RDY/MORE    page valid for host read / further data pending
//   WCOUNT           valid bytes in the reported page
//   IRQ_N            one-CLK low pulse whenever a page is reported
module smpc_port_poller #(
    parameter int NPORTS     = 2,
    parameter int OREG_DEPTH = 32,
    parameter int SETTLE     = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CE,
    input  logic                          START,
    input  logic                          CONT,
    input  logic                          BRK,
    input  logic [NPORTS-1:0]             PEN,
    output logic [7*NPORTS-1:0]           PO,
    input  logic [7*NPORTS-1:0]           PI,
    input  logic [$clog2(OREG_DEPTH)-1:0] RADDR,
    output logic [7:0]                    RDATA,
    output logic                          BUSY,
    output logic                          PAGE_RDY,
    output logic                          MORE,
    output logic [$clog2(OREG_DEPTH):0]   WCOUNT,
    output logic                          IRQ_N
);
    localparam int AW = $clog2(OREG_DEPTH);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = 16;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_REQ, S_ACK, S_EMIT, S_PAGE, S_FIN} state_t;
    // What happens after the pending byte is written
    typedef enum logic [1:0] {K_END, K_F1, K_DATA, K_FILL} kind_t;

    state_t         r_state, w_state_next;
    kind_t          r_kind;
    logic [PW-1:0]  r_port;
    logic           r_th, r_tr, r_hdr, r_nib;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_hi, r_remain;
    logic [7:0]     r_hdrb, r_pend, r_rdata;
    logic [AW:0]    r_idx, r_wcount;
    logic           r_busy, r_page_rdy, r_more, r_irq_n;
    logic [7:0]     r_buf [OREG_DEPTH];

    logic [6:0]     w_pi_sel;
    logic           w_match, w_tmo, w_settle, w_full, w_last, w_brk, w_emit_end;

    always_comb begin
        w_pi_sel = '1;
        for (int p = 0; p < NPORTS; p++)
            if (PW'(p) == r_port) w_pi_sel = PI[p*7 +: 7];
    end

    always_comb begin
        PO = '1;
        for (int p = 0; p < NPORTS; p++)
            if (PW'(p) == r_port) begin
                PO[p*7+6] = r_th;
                PO[p*7+5] = r_tr;
            end
    end

    assign w_match  = (w_pi_sel[4] == r_tr);
    assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
    assign w_settle = (r_cnt == CW'(SETTLE - 1));
    assign w_full   = (r_idx == (AW+1)'(OREG_DEPTH));
    assign w_last   = (r_port == PW'(NPORTS - 1));
    assign w_brk    = BRK && (r_state != S_IDLE) && (r_state != S_FIN);
    // Port is finished once its last byte (marker, final data or final fill) is written
    assign w_emit_end = (r_kind == K_END) ||
                        ((r_kind == K_DATA) && (r_remain == 4'd0)) ||
                        ((r_kind == K_FILL) && (r_remain == 4'd1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (CE) begin
            case (r_state)
                S_IDLE: if (START) w_state_next = S_SEL;
                S_SEL:  if (!PEN[r_port]) w_state_next = S_EMIT;
                        else if (w_settle) w_state_next = S_REQ;
                S_REQ:  w_state_next = S_ACK;
                S_ACK:  if (w_match) w_state_next = r_nib ? S_EMIT : S_REQ;
                        else if (w_tmo) w_state_next = S_EMIT;
                S_EMIT: if (w_full) w_state_next = S_PAGE;
                        else if (r_kind == K_F1) w_state_next = S_EMIT;
                        else if (w_emit_end) w_state_next = w_last ? S_FIN : S_SEL;
                        else if (r_kind == K_FILL) w_state_next = S_EMIT;
                        else w_state_next = S_REQ;
                S_PAGE: if (CONT) w_state_next = S_EMIT;
                S_FIN:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
            if (w_brk) w_state_next = S_FIN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_kind <= K_END;  r_port <= '0;  r_th <= 1'b1;  r_tr <= 1'b1;
            r_hdr <= 1'b1;    r_nib <= 1'b0; r_cnt <= '0;   r_hi <= '0;
            r_remain <= '0;   r_hdrb <= '0;  r_pend <= '0;  r_rdata <= '0;
            r_idx <= '0;      r_wcount <= '0;
            r_busy <= 1'b0;   r_page_rdy <= 1'b0; r_more <= 1'b0; r_irq_n <= 1'b1;
            for (int i = 0; i < OREG_DEPTH; i++) r_buf[i] <= '0;
        end else begin
            r_rdata <= r_buf[RADDR];
            r_irq_n <= 1'b1;
            if (CE) begin
                if (w_brk) begin
                    r_th <= 1'b1;
                    r_tr <= 1'b1;
                end else begin
                    case (r_state)
                        S_IDLE: if (START) begin
                            r_busy <= 1'b1; r_page_rdy <= 1'b0; r_more <= 1'b0;
                            r_idx <= '0;    r_port <= '0;       r_cnt <= '0;
                        end
                        S_SEL: if (!PEN[r_port]) begin
                            r_pend <= 8'hF0;
                            r_kind <= K_END;
                        end else begin
                            r_th <= 1'b0;  r_tr <= 1'b1;
                            r_hdr <= 1'b1; r_nib <= 1'b0;
                            r_cnt <= w_settle ? '0 : r_cnt + 1'b1;
                        end
                        S_REQ: begin
                            r_tr  <= ~r_tr;
                            r_cnt <= '0;
                        end
                        S_ACK: if (w_match) begin
                            r_cnt <= '0;
                            if (!r_nib) begin
                                r_hi  <= w_pi_sel[3:0];
                                r_nib <= 1'b1;
                            end else begin
                                r_nib <= 1'b0;
                                if (r_hdr) begin
                                    // Marker goes out first; header byte is held until after it
                                    r_hdr    <= 1'b0;
                                    r_remain <= w_pi_sel[3:0];
                                    r_hdrb   <= {r_hi, w_pi_sel[3:0]};
                                    r_pend   <= 8'hF1;
                                    r_kind   <= K_F1;
                                end else begin
                                    r_remain <= r_remain - 4'd1;
                                    r_pend   <= {r_hi, w_pi_sel[3:0]};
                                    r_kind   <= K_DATA;
                                end
                            end
                        end else if (w_tmo) begin
                            r_cnt  <= '0;
                            r_pend <= r_hdr ? 8'hF0 : 8'hFF;
                            r_kind <= r_hdr ? K_END : K_FILL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        S_EMIT: if (w_full) begin
                            r_wcount   <= (AW+1)'(OREG_DEPTH);
                            r_page_rdy <= 1'b1;
                            r_more     <= 1'b1;
                            r_irq_n    <= 1'b0;
                        end else begin
                            r_buf[r_idx[AW-1:0]] <= r_pend;
                            r_idx <= r_idx + 1'b1;
                            r_cnt <= '0;
                            if (r_kind == K_F1) begin
                                r_pend <= r_hdrb;
                                r_kind <= K_DATA;
                            end else if (w_emit_end) begin
                                r_th   <= 1'b1;
                                r_tr   <= 1'b1;
                                r_port <= r_port + 1'b1;
                            end else if (r_kind == K_FILL) begin
                                r_remain <= r_remain - 4'd1;
                            end
                        end
                        S_PAGE: if (CONT) begin
                            r_page_rdy <= 1'b0;
                            r_idx      <= '0;
                        end
                        S_FIN: begin
                            r_wcount   <= r_idx;
                            r_page_rdy <= 1'b1;
                            r_more     <= 1'b0;
                            r_irq_n    <= 1'b0;
                            r_busy     <= 1'b0;
                            r_th       <= 1'b1;
                            r_tr       <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign RDATA    = r_rdata;
    assign BUSY     = r_busy;
    assign PAGE_RDY = r_page_rdy;
    assign MORE     = r_more;
    assign WCOUNT   = r_wcount;
    assign IRQ_N    = r_irq_n;
endmodule

// File: tb/tb_smpc_port_poller.sv
// tb/tb_smpc_port_poller.sv - directed self-checking bench for smpc_port_poller
module tb_smpc_port_poller;
    logic        CLK = 1'b0;
    logic        RST_N, CE, START, CONT, BRK;
    logic [1:0]  PEN;
    logic [13:0] PO, PI;
    logic [4:0]  RADDR;
    logic [7:0]  RDATA;
    logic        BUSY, PAGE_RDY, MORE, IRQ_N;
    logic [5:0]  WCOUNT;

    int n_cmp = 0;
    int n_err = 0;
    int irq_cnt = 0;
    int th_low_cnt = 0;
    int last_wait = 0;
    int irq0, th0;

    // Peripheral model: answers each TR change with the next nibble until its list runs out
    logic [3:0] m_nib [2][40];
    int         m_len [2];
    int         m_ptr [2];
    logic [1:0] m_tl = 2'b11;
    logic [3:0] m_d [2];

    always #5 CLK = ~CLK;

    smpc_port_poller dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START), .CONT(CONT), .BRK(BRK),
        .PEN(PEN), .PO(PO), .PI(PI), .RADDR(RADDR), .RDATA(RDATA), .BUSY(BUSY),
        .PAGE_RDY(PAGE_RDY), .MORE(MORE), .WCOUNT(WCOUNT), .IRQ_N(IRQ_N)
    );

    assign PI[6:0]  = {2'b11, m_tl[0], m_d[0]};
    assign PI[13:7] = {2'b11, m_tl[1], m_d[1]};

    always @(negedge CLK) begin
        for (int p = 0; p < 2; p++) begin
            if (PO[p*7+6]) begin
                m_ptr[p] = 0;
                m_tl[p]  = 1'b1;
            end else if (m_tl[p] != PO[p*7+5] && m_ptr[p] < m_len[p]) begin
                m_d[p]  = m_nib[p][m_ptr[p]];
                m_tl[p] = PO[p*7+5];
                m_ptr[p]++;
            end
        end
        if (IRQ_N === 1'b0) irq_cnt++;
        if (PO[6] === 1'b0 || PO[13] === 1'b0) th_low_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int p, input int i, input logic [7:0] b);
        m_nib[p][2*i]   = b[7:4];
        m_nib[p][2*i+1] = b[3:0];
    endtask

    task automatic chkbuf(input string tag, input int a, input logic [7:0] exp);
        RADDR = 5'(a);
        @(negedge CLK);
        @(negedge CLK);
        chk(tag, RDATA, exp);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_page(input string tag);
        int n = 0;
        while (PAGE_RDY !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        last_wait = n;
        chk(tag, PAGE_RDY, 1'b1);
    endtask

    task automatic wait_th1_low(input string tag);
        int n = 0;
        while (PO[13] !== 1'b0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, PO[13], 1'b0);
    endtask

    task automatic cfg_basic();
        put(0, 0, 8'h02); put(0, 1, 8'hFF); put(0, 2, 8'hF7);
        m_len[0] = 6;
        m_len[1] = 0;
    endtask

    initial begin
        RST_N = 1'b0; CE = 1'b1; START = 1'b0; CONT = 1'b0; BRK = 1'b0;
        PEN = 2'b11; RADDR = '0;
        m_len[0] = 0; m_len[1] = 0;
        repeat (3) @(negedge CLK);
        chk("rst_po", PO, 14'h3FFF);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_page_rdy", PAGE_RDY, 1'b0);
        chk("rst_more", MORE, 1'b0);
        chk("rst_wcount", WCOUNT, 6'd0);
        chk("rst_irq_n", IRQ_N, 1'b1);
        chk("rst_rdata", RDATA, 8'h00);
        RST_N = 1'b1;
        @(negedge CLK);

        // Basic scan: port0 answers header 02 + FF F7, port1 silent
        cfg_basic();
        irq0 = irq_cnt;
        pulse_start();
        chk("t1_busy", BUSY, 1'b1);
        wait_page("t1_page");
        @(negedge CLK);
        chk("t1_wcount", WCOUNT, 6'd5);
        chk("t1_more", MORE, 1'b0);
        chk("t1_busy_end", BUSY, 1'b0);
        chk("t1_po", PO, 14'h3FFF);
        chk("t1_irq", irq_cnt - irq0, 1);
        chkbuf("t1_b0", 0, 8'hF1);
        chkbuf("t1_b1", 1, 8'h02);
        chkbuf("t1_b2", 2, 8'hFF);
        chkbuf("t1_b3", 3, 8'hF7);
        chkbuf("t1_b4", 4, 8'hF0);

        // Two full ports of 17 bytes each: 32-byte page then a 2-byte page
        put(0, 0, 8'h0F);
        put(1, 0, 8'h1F);
        for (int k = 0; k < 15; k++) begin
            put(0, k + 1, 8'(k));
            put(1, k + 1, 8'h80 + 8'(k));
        end
        m_len[0] = 32; m_len[1] = 32;
        irq0 = irq_cnt;
        pulse_start();
        wait_page("t2_page1");
        chk("t2_wcount1", WCOUNT, 6'd32);
        chk("t2_more1", MORE, 1'b1);
        chk("t2_busy1", BUSY, 1'b1);
        chkbuf("t2_b1", 1, 8'h0F);
        chkbuf("t2_b16", 16, 8'h0E);
        chkbuf("t2_b17", 17, 8'hF1);
        chkbuf("t2_b18", 18, 8'h1F);
        chkbuf("t2_b31", 31, 8'h8C);
        CONT = 1'b1;
        @(negedge CLK);
        CONT = 1'b0;
        chk("t2_rdy_drop", PAGE_RDY, 1'b0);
        wait_page("t2_page2");
        @(negedge CLK);
        chk("t2_wcount2", WCOUNT, 6'd2);
        chk("t2_more2", MORE, 1'b0);
        chk("t2_busy2", BUSY, 1'b0);
        chk("t2_irq", irq_cnt - irq0, 2);
        chkbuf("t2_p2b0", 0, 8'h8D);
        chkbuf("t2_p2b1", 1, 8'h8E);
        chkbuf("t2_p2b5_old", 5, 8'h03);

        // Port0 stops after 3 of 6 data bytes; port1 disabled
        PEN = 2'b01;
        put(0, 0, 8'h06); put(0, 1, 8'h11); put(0, 2, 8'h22); put(0, 3, 8'h33);
        m_len[0] = 8;
        pulse_start();
        wait_page("t3_page");
        chk("t3_one_timeout", (last_wait > 255 && last_wait < 400), 1'b1);
        @(negedge CLK);
        chk("t3_wcount", WCOUNT, 6'd9);
        chkbuf("t3_b1", 1, 8'h06);
        chkbuf("t3_b4", 4, 8'h33);
        chkbuf("t3_b5", 5, 8'hFF);
        chkbuf("t3_b6", 6, 8'hFF);
        chkbuf("t3_b7", 7, 8'hFF);
        chkbuf("t3_b8", 8, 8'hF0);
        chkbuf("t3_b9_old", 9, 8'h07);

        // No ports enabled
        PEN = 2'b00;
        th0 = th_low_cnt;
        pulse_start();
        wait_page("t4_page");
        @(negedge CLK);
        chk("t4_wcount", WCOUNT, 6'd2);
        chk("t4_th_never_low", th_low_cnt - th0, 0);
        chkbuf("t4_b0", 0, 8'hF0);
        chkbuf("t4_b1", 1, 8'hF0);
        chkbuf("t4_b2_old", 2, 8'h11);

        // BRK while port1 waits for an acknowledge, START in the same cycle
        PEN = 2'b11;
        put(0, 0, 8'h30);
        m_len[0] = 2; m_len[1] = 0;
        irq0 = irq_cnt;
        pulse_start();
        wait_th1_low("t5_th1_low");
        repeat (20) @(negedge CLK);
        BRK = 1'b1; START = 1'b1;
        @(negedge CLK);
        BRK = 1'b0; START = 1'b0;
        wait_page("t5_page");
        chk("t5_more", MORE, 1'b0);
        chk("t5_po", PO, 14'h3FFF);
        chk("t5_busy", BUSY, 1'b0);
        chk("t5_wcount", WCOUNT, 6'd2);
        repeat (5) @(negedge CLK);
        chk("t5_start_ignored", BUSY, 1'b0);
        chk("t5_irq", irq_cnt - irq0, 1);
        chkbuf("t5_b1", 1, 8'h30);

        // Asynchronous reset during an acknowledge wait, then a normal scan
        cfg_basic();
        pulse_start();
        wait_th1_low("t6_th1_low");
        repeat (20) @(negedge CLK);
        irq0 = irq_cnt;
        #2 RST_N = 1'b0;
        #1;
        chk("t6_po", PO, 14'h3FFF);
        chk("t6_busy", BUSY, 1'b0);
        chk("t6_page_rdy", PAGE_RDY, 1'b0);
        chk("t6_wcount", WCOUNT, 6'd0);
        chk("t6_irq_n", IRQ_N, 1'b1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("t6_no_page", irq_cnt - irq0, 0);
        pulse_start();
        wait_page("t6_page");
        @(negedge CLK);
        chk("t6_wcount2", WCOUNT, 6'd5);
        chkbuf("t6_b0", 0, 8'hF1);
        chkbuf("t6_b3", 3, 8'hF7);
        chkbuf("t6_b4", 4, 8'hF0);
        chkbuf("t6_b5_cleared", 5, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
